// File: rtl/booth_seq_mult_pkg.sv
// Shared types and sizing for the sequential Booth multiplier.
package mult_pkg;

   localparam int MULT_N  = 4;
   localparam int MULT_PW = 2 * MULT_N;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_e;

endpackage

// File: rtl/booth_seq_mult_if.sv
// Start/done product bus between a requester (master) and the multiplier (slave).
// Optional absolute-value outputs exist only when MULT_ABS_OUT_EN is defined.
interface booth_seq_mult_if #(
   parameter int N = mult_pkg::MULT_N
);
   import mult_pkg::*;

   // Handshake: start is sampled only while busy=0; the operands are captured in
   // that same cycle. done pulses for one cycle with product valid; product then
   // holds until the next done. A start seen while busy=1 is dropped, never queued.
   logic           start;
   logic [N-1:0]   a;
   logic [N-1:0]   b;
   logic           busy;
   logic           done;
   logic [2*N-1:0] product;
   state_e         dbg_state;
`ifdef MULT_ABS_OUT_EN
   logic           prod_neg;
   logic [2*N-1:0] prod_mag;

   modport master (output start, a, b,
                   input  busy, done, product, dbg_state, prod_neg, prod_mag);
   modport slave  (input  start, a, b,
                   output busy, done, product, dbg_state, prod_neg, prod_mag);
`else
   modport master (output start, a, b,
                   input  busy, done, product, dbg_state);
   modport slave  (input  start, a, b,
                   output busy, done, product, dbg_state);
`endif

endinterface

// File: rtl/booth_seq_mult_booth_step.sv
// One radix-2 Booth iteration: conditional add/subtract of the multiplicand,
// then an arithmetic right shift of {acc, q, q_m1}.
module booth_step #(
   parameter int N = mult_pkg::MULT_N
) (
   input  logic [N:0]   acc_i,
   input  logic [N-1:0] q_i,
   input  logic         q_m1_i,
   input  logic [N:0]   mcand_i,
   output logic [N:0]   acc_o,
   output logic [N-1:0] q_o,
   output logic         q_m1_o
);

   logic [N:0] sum;

   always_comb begin
      sum = acc_i;
      case ({q_i[0], q_m1_i})
         2'b01:   sum = acc_i + mcand_i;
         2'b10:   sum = acc_i - mcand_i;
         default: sum = acc_i;
      endcase
      acc_o  = {sum[N], sum[N:1]};
      q_o    = {sum[0], q_i[N-1:1]};
      q_m1_o = q_i[0];
   end

endmodule

// File: rtl/booth_seq_mult.sv
// Sequential radix-2 Booth multiplier, N+1 cycles per signed N x N multiply.
// Define MULT_ABS_OUT_EN to add registered prod_neg/prod_mag outputs.
module booth_seq_mult
   import mult_pkg::*;
#(
   parameter int N = MULT_N
) (
   input  logic             clk,
   input  logic             rst_n,
   booth_seq_mult_if.slave  bus
);

   localparam int CW = $clog2(N + 1);
   localparam int PW = 2 * N;
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   state_e         state_q, state_d;
   logic [N:0]     acc_q, acc_d;
   logic [N-1:0]   q_q, q_d;
   logic           q_m1_q, q_m1_d;
   logic [N:0]     mcand_q, mcand_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [PW-1:0]  product_q, product_d;

   logic [N:0]     step_acc;
   logic [N-1:0]   step_q;
   logic           step_q_m1;

`ifdef MULT_ABS_OUT_EN
   logic           prod_neg_q, prod_neg_d;
   logic [PW-1:0]  prod_mag_q, prod_mag_d;
`endif

   booth_step #(.N(N)) u_step (
      .acc_i   (acc_q),
      .q_i     (q_q),
      .q_m1_i  (q_m1_q),
      .mcand_i (mcand_q),
      .acc_o   (step_acc),
      .q_o     (step_q),
      .q_m1_o  (step_q_m1)
   );

   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      q_d       = q_q;
      q_m1_d    = q_m1_q;
      mcand_d   = mcand_q;
      cnt_d     = cnt_q;
      product_d = product_q;
`ifdef MULT_ABS_OUT_EN
      prod_neg_d = prod_neg_q;
      prod_mag_d = prod_mag_q;
`endif
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               acc_d   = '0;
               q_d     = bus.b;
               q_m1_d  = 1'b0;
               mcand_d = {bus.a[N-1], bus.a};
               cnt_d   = '0;
               state_d = CALC;
            end
         end
         CALC: begin
            acc_d  = step_acc;
            q_d    = step_q;
            q_m1_d = step_q_m1;
            cnt_d  = cnt_q + CW'(1);
            // Last iteration: the product is taken straight from the step outputs.
            if (cnt_q == LAST) begin
               state_d   = DONE;
               product_d = {step_acc[N-1:0], step_q};
`ifdef MULT_ABS_OUT_EN
               prod_neg_d = product_d[PW-1];
               prod_mag_d = prod_neg_d ? (~product_d) + PW'(1) : product_d;
`endif
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         acc_q     <= '0;
         q_q       <= '0;
         q_m1_q    <= 1'b0;
         mcand_q   <= '0;
         cnt_q     <= '0;
         product_q <= '0;
`ifdef MULT_ABS_OUT_EN
         prod_neg_q <= 1'b0;
         prod_mag_q <= '0;
`endif
      end else begin
         state_q   <= state_d;
         acc_q     <= acc_d;
         q_q       <= q_d;
         q_m1_q    <= q_m1_d;
         mcand_q   <= mcand_d;
         cnt_q     <= cnt_d;
         product_q <= product_d;
`ifdef MULT_ABS_OUT_EN
         prod_neg_q <= prod_neg_d;
         prod_mag_q <= prod_mag_d;
`endif
      end
   end

   assign bus.busy      = (state_q != IDLE);
   assign bus.done      = (state_q == DONE);
   assign bus.product   = product_q;
   assign bus.dbg_state = state_q;
`ifdef MULT_ABS_OUT_EN
   assign bus.prod_neg  = prod_neg_q;
   assign bus.prod_mag  = prod_mag_q;
`endif

endmodule

// File: tb/tb_booth_seq_mult.sv
// Self-checking bench for booth_seq_mult: directed table, exhaustive sweep,
// random operands and multi-cycle corner sequences against an arithmetic model.
module tb_booth_seq_mult;
   import mult_pkg::*;

   localparam int N  = MULT_N;
   localparam int PW = MULT_PW;

   typedef struct {
      logic [N-1:0]  a;
      logic [N-1:0]  b;
      logic [PW-1:0] exp;
   } vec_t;

   logic clk;
   logic rst_n;
   int   n_checks = 0;
   int   n_fail   = 0;
   int   done_cnt = 0;
   logic [PW-1:0] exp_q[$];

   booth_seq_mult_if #(.N(N)) mif ();

   booth_seq_mult #(.N(N)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (mif.slave)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
      $fatal(1, "watchdog");
   end

   function automatic void check(input string name, input logic [63:0] got,
                                 input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h required %0h", name, got, exp);
      end
   endfunction

   // Reference model: plain signed arithmetic on sign-extended operands.
   function automatic logic [PW-1:0] model(input int av, input int bv);
      return PW'(av * bv);
   endfunction

   function automatic int sx(input logic [N-1:0] v);
      return v[N-1] ? int'(v) - (1 << N) : int'(v);
   endfunction

   // scoreboard: every done pops one expected product
   always @(negedge clk) begin
      if (rst_n && mif.done) begin
         logic [PW-1:0] e;
         done_cnt++;
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_done: got done with product %0h, required no done", mif.product);
         end else begin
            e = exp_q.pop_front();
            check("product", mif.product, e);
`ifdef MULT_ABS_OUT_EN
            check("prod_neg", mif.prod_neg, e[PW-1]);
            check("prod_mag", mif.prod_mag, e[PW-1] ? PW'(-int'(e) + (1 << PW)) : e);
`endif
         end
      end
   end

   // drivers
   task automatic start_mult(input logic [N-1:0] av, input logic [N-1:0] bv,
                             input logic [PW-1:0] exp);
      int guard = 0;
      @(negedge clk);
      while (mif.busy && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      if (mif.busy) begin
         n_checks++;
         n_fail++;
         $display("FAIL idle_wait: got busy=1 after 20 cycles, required busy=0");
      end
      mif.start = 1'b1;
      mif.a     = av;
      mif.b     = bv;
      exp_q.push_back(exp);
      @(negedge clk);
      mif.start = 1'b0;
      mif.a     = N'($urandom);
      mif.b     = N'($urandom);
   endtask

   task automatic wait_done();
      int c0 = done_cnt;
      for (int i = 0; i < 20; i++) begin
         if (done_cnt != c0) break;
         @(negedge clk);
         #1;
      end
      check("done_seen", (done_cnt != c0), 1);
   endtask

   vec_t vecs[6];

   initial begin
      int c0;
      rst_n     = 1'b0;
      mif.start = 1'b0;
      mif.a     = '0;
      mif.b     = '0;

      vecs[0] = '{a: 4'd3,  b: 4'd5,  exp: 8'h0F};
      vecs[1] = '{a: 4'h8,  b: 4'h8,  exp: 8'h40};
      vecs[2] = '{a: 4'h8,  b: 4'd7,  exp: 8'hC8};
      vecs[3] = '{a: 4'd0,  b: 4'hB,  exp: 8'h00};
      vecs[4] = '{a: 4'd7,  b: 4'd0,  exp: 8'h00};
      vecs[5] = '{a: 4'hA,  b: 4'd7,  exp: 8'hD6};

      repeat (3) @(negedge clk);
      check("rst_busy", mif.busy, 0);
      check("rst_done", mif.done, 0);
      check("rst_product", mif.product, 0);
      check("rst_state", mif.dbg_state, IDLE);
`ifdef MULT_ABS_OUT_EN
      check("rst_prod_neg", mif.prod_neg, 0);
      check("rst_prod_mag", mif.prod_mag, 0);
`endif
      rst_n = 1'b1;

      // latency and busy window for 3*5
      start_mult(4'd3, 4'd5, 8'h0F);
      for (int i = 1; i <= 6; i++) begin
         if (i > 1) @(negedge clk);
         check($sformatf("lat_busy_%0d", i), mif.busy, (i <= N + 1));
         check($sformatf("lat_done_%0d", i), mif.done, (i == N + 1));
      end

      // directed table
      for (int i = 0; i < 6; i++) begin
         start_mult(vecs[i].a, vecs[i].b, vecs[i].exp);
         wait_done();
      end

      // exhaustive sweep
      for (int ia = -8; ia < 8; ia++) begin
         for (int ib = -8; ib < 8; ib++) begin
            start_mult(N'(ia), N'(ib), model(ia, ib));
            wait_done();
         end
      end

      // random operands with random idle gaps
      for (int i = 0; i < 40; i++) begin
         logic [N-1:0] ra, rb;
         ra = N'($urandom_range(0, 15));
         rb = N'($urandom_range(0, 15));
         repeat ($urandom_range(0, 2)) @(negedge clk);
         start_mult(ra, rb, model(sx(ra), sx(rb)));
         wait_done();
      end

      // start re-pulsed during CALC is ignored
      c0 = done_cnt;
      start_mult(4'd3, 4'd5, 8'h0F);
      @(negedge clk);
      mif.start = 1'b1;
      mif.a     = 4'd7;
      mif.b     = 4'd7;
      @(negedge clk);
      mif.start = 1'b0;
      repeat (12) @(negedge clk);
      check("ignored_start_dones", done_cnt - c0, 1);
      check("ignored_start_product", mif.product, 8'h0F);

      // reset during CALC cycle 3 aborts
      start_mult(4'd5, 4'd3, 8'h0F);
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("abort_busy", mif.busy, 0);
      check("abort_done", mif.done, 0);
      check("abort_product", mif.product, 0);
      check("abort_state", mif.dbg_state, IDLE);
      exp_q.delete();
      c0 = done_cnt;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      check("abort_no_done", done_cnt, c0);
      start_mult(4'hD, 4'd4, 8'hF4);
      wait_done();

      // start held high retriggers every N+2 cycles
      c0 = done_cnt;
      for (int i = 0; i < 3; i++) exp_q.push_back(model(2, -3));
      @(negedge clk);
      mif.start = 1'b1;
      mif.a     = 4'd2;
      mif.b     = 4'hD;
      for (int i = 1; i <= 3 * (N + 2); i++) begin
         @(negedge clk);
         check($sformatf("held_done_%0d", i), mif.done, (i % (N + 2)) == N + 1);
      end
      mif.start = 1'b0;
      repeat (10) @(negedge clk);
      check("held_done_count", done_cnt - c0, 3);
      check("held_queue_empty", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/booth_seq_mult.md
# booth_seq_mult

Sequential radix-2 Booth multiplier for two signed N-bit operands, producing a 2N-bit two's-complement product with a start/done handshake. It is the producer side of the product bus. Its registered product feeds the per-anode 7-segment decoders (tens, units, sign) of the multiplier display path. One Booth iteration is retired per clock, so a multiply takes a fixed N+1 cycles.

## Interface
- N, default 4: operand width in bits, signed. The product is 2N bits wide.
- clk, input, 1: single rising-edge clock.
- rst_n, input, 1: reset, asynchronous and active-low.
- start, input, 1: request a multiply. Sampled only in IDLE.
- a, input, N: multiplicand, signed. Captured on an accepted start.
- b, input, N: multiplier, signed. Captured on an accepted start.
- busy, output, 1: high while in CALC or DONE.
- done, output, 1: one-cycle pulse, asserted together with the product update.
- product, output, 2N: signed product. Holds its value until the next done.

## Operation
- FSM states: IDLE, CALC, DONE.
  - IDLE with start=1: capture the operands, go to CALC.
  - CALC: stay exactly N cycles, then go to DONE.
  - DONE: go to IDLE unconditionally.
- Working registers:
  - acc: N+1 bits, signed. Extra bit so that negating a = −2^(N−1) does not overflow.
  - q: N bits.
  - q_m1: 1 bit.
  - mcand: N+1 bits, sign-extended a.
  - cnt: ceil(log2(N+1)) bits.
- On accept: acc=0, q=b, q_m1=0, mcand=sext(a), cnt=0.
- Each CALC cycle, select on {q[0], q_m1}:
  - 01: acc += mcand.
  - 10: acc −= mcand.
  - 00 and 11: no change.
  - Then arithmetic-shift {acc, q, q_m1} right by one, and cnt += 1.
- On leaving CALC: product ← low 2N bits of {acc, q}.
  - This is exact for every operand pair, including (−2^(N−1))², which is +64 = 8'h40 for N=4.
- A start while busy is ignored: no queueing, no error.
- Operands are not re-sampled until the next accepted start.

## Timing
- Reset values (asynchronous, immediate): state=IDLE, busy=0, done=0, product=0, all working registers 0.
- Latency: for a start accepted at edge T:
  - busy=1 from T+1 through T+N+1.
  - product updates and done=1 for the single cycle after edge T+N+1.
  - For N=4: done is high N+1 = 5 cycles after the start cycle.
- done is high only while in DONE. busy and done are both high in that cycle.
- Earliest next accepted start: the first IDLE cycle after DONE. Sustained throughput is one multiply per N+2 cycles.
- A start held high continuously re-triggers a new multiply on every IDLE cycle.
- Reset asserted mid-CALC or in DONE:
  - Abort immediately and clear product to 0.
  - No done pulse is emitted for the aborted operation.
- a and b may change freely after the accept cycle without affecting the result.

## Configuration
- Macro: MULT_ABS_OUT_EN.
- Defined: adds two extra outputs, registered alongside product and reset to 0.
  - prod_neg, output, 1: equals product[2N−1].
  - prod_mag, output, 2N: absolute value of product.
  - These drive the display sign segment and the digit decoders without a downstream negation.
- Undefined: the ports and their logic are absent. All other behaviour is identical.

## Structure
- Shared package mult_pkg holds:
  - the state enum (IDLE, CALC, DONE);
  - the default operand width MULT_N = 4;
  - the product width constant MULT_PW = 2*MULT_N.
- One sub-module, booth_step: combinational single iteration.
  - Inputs: acc, q, q_m1, mcand.
  - Outputs: next acc, q, q_m1.
  - Instantiated once and reused every CALC cycle.

## Test plan
- a=3, b=5, start pulsed one cycle → done exactly 5 cycles later; product=8'h0F; busy high for 5 cycles.
- a=−8, b=−8 → product=8'h40 (+64). a=−8, b=7 → product=8'hC8 (−56).
- a=0, b=−5, then a=7, b=0 → product=8'h00 both times. Exhaustive sweep of all 256 pairs matches a*b.
- start re-pulsed at cycle 2 of an active multiply with different operands → ignored; first result unchanged; only one done.
- rst_n driven low during CALC cycle 3 → busy, done and product go to 0 immediately; no done after release; next start works normally.
- With MULT_ABS_OUT_EN: a=−6, b=7 → product=8'hD6, prod_neg=1, prod_mag=8'd42.
